// File: rtl/ysyx_22041211_wbu_pkg.sv
// Shared definitions for the write-back stage: CSR operation codes, CSR addresses,
// reset constants and the write-back FSM state encoding.
package ysyx_22041211_wbu_pkg;

    typedef enum logic [2:0] {
        CSR_TYPE_NONE  = 3'b000,
        CSR_TYPE_CSRW  = 3'b001,
        CSR_TYPE_ECALL = 3'b010,
        CSR_TYPE_MRET  = 3'b011
    } csr_type_e;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

    localparam logic [31:0] MCAUSE_ECALL_M = 32'd11;
    localparam logic [31:0] MSTATUS_RESET  = 32'h0000_1800;

    typedef enum logic [1:0] {
        WB_IDLE   = 2'd0,
        WB_COMMIT = 2'd1,
        WB_DONE   = 2'd2
    } wb_state_e;

    // Reserved codes 100-111 collapse to NONE so downstream logic sees only four cases.
    function automatic csr_type_e decode_csr_type(input logic [2:0] raw);
        case (raw)
            3'b001:  return CSR_TYPE_CSRW;
            3'b010:  return CSR_TYPE_ECALL;
            3'b011:  return CSR_TYPE_MRET;
            default: return CSR_TYPE_NONE;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_22041211_csr_file.sv
// Machine-mode CSR file: mstatus/mtvec/mepc/mcause, write decode and combinational read mux.
// Optional 64-bit minstret counter is built when YSYX_22041211_WBU_INSTRET_EN is defined.
module ysyx_22041211_csr_file
    import ysyx_22041211_wbu_pkg::*;
#(
    parameter int DATA_LEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                csr_we_i,
    input  logic [11:0]         csr_waddr_i,
    input  logic [DATA_LEN-1:0] csr_wdata_i,
    input  logic                ecall_i,
    input  logic [DATA_LEN-1:0] epc_i,
    input  logic                instret_inc_i,
    input  logic [11:0]         csr_raddr_i,
    output logic [DATA_LEN-1:0] csr_rdata_o,
    output logic [DATA_LEN-1:0] mtvec_o,
    output logic [DATA_LEN-1:0] mepc_o
);

    logic [DATA_LEN-1:0] mstatus_q, mstatus_d;
    logic [DATA_LEN-1:0] mtvec_q,   mtvec_d;
    logic [DATA_LEN-1:0] mepc_q,    mepc_d;
    logic [DATA_LEN-1:0] mcause_q,  mcause_d;

`ifdef YSYX_22041211_WBU_INSTRET_EN
    logic [63:0] minstret_q, minstret_d;
`else
    logic unused_instret_inc;
    assign unused_instret_inc = instret_inc_i;
`endif

    // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        mstatus_d = mstatus_q;
        mtvec_d   = mtvec_q;
        mepc_d    = mepc_q;
        mcause_d  = mcause_q;
`ifdef YSYX_22041211_WBU_INSTRET_EN
        minstret_d = minstret_q;
        if (instret_inc_i) minstret_d = minstret_q + 64'd1;
`endif
        if (csr_we_i) begin
            case (csr_waddr_i)
                CSR_MSTATUS: mstatus_d = csr_wdata_i;
                CSR_MTVEC:   mtvec_d   = csr_wdata_i;
                CSR_MEPC:    mepc_d    = csr_wdata_i;
                CSR_MCAUSE:  mcause_d  = csr_wdata_i;
`ifdef YSYX_22041211_WBU_INSTRET_EN
                // An explicit write wins over the retire increment.
                CSR_MINSTRET:  minstret_d[31:0]  = csr_wdata_i[31:0];
                CSR_MINSTRETH: minstret_d[63:32] = csr_wdata_i[31:0];
`endif
                default: ;
            endcase
        end
        if (ecall_i) begin
            mepc_d   = epc_i;
            mcause_d = DATA_LEN'(MCAUSE_ECALL_M);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_q <= DATA_LEN'(MSTATUS_RESET);
            mtvec_q   <= '0;
            mepc_q    <= '0;
            mcause_q  <= '0;
`ifdef YSYX_22041211_WBU_INSTRET_EN
            minstret_q <= '0;
`endif
        end else begin
            mstatus_q <= mstatus_d;
            mtvec_q   <= mtvec_d;
            mepc_q    <= mepc_d;
            mcause_q  <= mcause_d;
`ifdef YSYX_22041211_WBU_INSTRET_EN
            minstret_q <= minstret_d;
`endif
        end
    end

    // Reads see the registered value, so a same-cycle write is visible only next cycle.
    always_comb begin
        csr_rdata_o = '0;
        case (csr_raddr_i)
            CSR_MSTATUS: csr_rdata_o = mstatus_q;
            CSR_MTVEC:   csr_rdata_o = mtvec_q;
            CSR_MEPC:    csr_rdata_o = mepc_q;
            CSR_MCAUSE:  csr_rdata_o = mcause_q;
`ifdef YSYX_22041211_WBU_INSTRET_EN
            CSR_MINSTRET:  csr_rdata_o = DATA_LEN'(minstret_q[31:0]);
            CSR_MINSTRETH: csr_rdata_o = DATA_LEN'(minstret_q[63:32]);
`endif
            default: ;
        endcase
    end

    assign mtvec_o = mtvec_q;
    assign mepc_o  = mepc_q;

endmodule

// File: rtl/ysyx_22041211_wbu.sv
// Write-back stage: latches one LSU result, commits GPR/CSR effects, then signals the IFU.
// Define YSYX_22041211_WBU_INSTRET_EN to add the minstret counter in the CSR file.
module ysyx_22041211_wbu
    import ysyx_22041211_wbu_pkg::*;
#(
    parameter int DATA_LEN = 32,
    parameter int ADDR_LEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                lsu_valid_i,
    input  logic                wd_i,
    input  logic [4:0]          wreg_i,
    input  logic [DATA_LEN-1:0] wdata_i,
    input  logic [2:0]          csr_type_i,
    input  logic [11:0]         csr_addr_i,
    input  logic [DATA_LEN-1:0] csr_wdata_i,
    input  logic [ADDR_LEN-1:0] pc_i,
    output logic                wb_ready_o,
    output logic                reg_wen_o,
    output logic [4:0]          reg_waddr_o,
    output logic [DATA_LEN-1:0] reg_wdata_o,
    input  logic [11:0]         csr_raddr_i,
    output logic [DATA_LEN-1:0] csr_rdata_o,
    output logic                wb_valid_o,
    output logic                redirect_o,
    output logic [ADDR_LEN-1:0] redirect_pc_o
);

    wb_state_e state_q, state_d;

    logic                wd_q;
    logic [4:0]          wreg_q;
    logic [DATA_LEN-1:0] wdata_q;
    csr_type_e           csr_type_q;
    logic [11:0]         csr_addr_q;
    logic [DATA_LEN-1:0] csr_wdata_q;
    logic [ADDR_LEN-1:0] pc_q;

    logic                commit, done, is_trap;
    logic [DATA_LEN-1:0] mtvec, mepc;

    always_comb begin
        state_d = state_q;
        case (state_q)
            WB_IDLE:   if (lsu_valid_i) state_d = WB_COMMIT;
            WB_COMMIT: state_d = WB_DONE;
            WB_DONE:   state_d = WB_IDLE;
            default:   state_d = WB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= WB_IDLE;
            wd_q        <= 1'b0;
            wreg_q      <= '0;
            wdata_q     <= '0;
            csr_type_q  <= CSR_TYPE_NONE;
            csr_addr_q  <= '0;
            csr_wdata_q <= '0;
            pc_q        <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == WB_IDLE && lsu_valid_i) begin
                wd_q        <= wd_i;
                wreg_q      <= wreg_i;
                wdata_q     <= wdata_i;
                csr_type_q  <= decode_csr_type(csr_type_i);
                csr_addr_q  <= csr_addr_i;
                csr_wdata_q <= csr_wdata_i;
                pc_q        <= pc_i;
            end
        end
    end

    // Strobes are masked by rst so a reset landing mid-commit discards the write that cycle.
    assign commit  = (state_q == WB_COMMIT) && !rst;
    assign done    = (state_q == WB_DONE) && !rst;
    assign is_trap = (csr_type_q == CSR_TYPE_ECALL) || (csr_type_q == CSR_TYPE_MRET);

    assign wb_ready_o  = (state_q == WB_IDLE);
    assign reg_wen_o   = commit && wd_q && (wreg_q != 5'd0);
    assign reg_waddr_o = wreg_q;
    assign reg_wdata_o = wdata_q;
    assign wb_valid_o  = done;
    assign redirect_o  = done && is_trap;

    always_comb begin
        redirect_pc_o = '0;
        if (redirect_o)
            redirect_pc_o = (csr_type_q == CSR_TYPE_ECALL) ? ADDR_LEN'(mtvec) : ADDR_LEN'(mepc);
    end

    ysyx_22041211_csr_file #(
        .DATA_LEN (DATA_LEN)
    ) u_csr_file (
        .clk           (clk),
        .rst           (rst),
        .csr_we_i      (commit && (csr_type_q == CSR_TYPE_CSRW)),
        .csr_waddr_i   (csr_addr_q),
        .csr_wdata_i   (csr_wdata_q),
        .ecall_i       (commit && (csr_type_q == CSR_TYPE_ECALL)),
        .epc_i         (DATA_LEN'(pc_q)),
        .instret_inc_i (done),
        .csr_raddr_i   (csr_raddr_i),
        .csr_rdata_o   (csr_rdata_o),
        .mtvec_o       (mtvec),
        .mepc_o        (mepc)
    );

endmodule

// File: tb/tb_ysyx_22041211_wbu.sv
// Self-checking bench for ysyx_22041211_wbu: a CSR model plus a scoreboard of expected
// commits, one task per scenario.
module tb_ysyx_22041211_wbu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lsu_valid_i = 1'b0;
    logic        wd_i = 1'b0;
    logic [4:0]  wreg_i = '0;
    logic [31:0] wdata_i = '0;
    logic [2:0]  csr_type_i = '0;
    logic [11:0] csr_addr_i = '0;
    logic [31:0] csr_wdata_i = '0;
    logic [31:0] pc_i = '0;
    logic [11:0] csr_raddr_i = '0;
    logic        wb_ready_o, reg_wen_o, wb_valid_o, redirect_o;
    logic [4:0]  reg_waddr_o;
    logic [31:0] reg_wdata_o, csr_rdata_o, redirect_pc_o;

    int tests_run = 0;
    int fails = 0;

    typedef struct {
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        redir;
        logic [31:0] rpc;
        logic [31:0] rd_commit;
        logic [31:0] rd_done;
    } exp_t;
    exp_t sb[$];

    logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause;
    logic [63:0] m_instret;

    ysyx_22041211_wbu dut (
        .clk(clk), .rst(rst), .lsu_valid_i(lsu_valid_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .wdata_i(wdata_i), .csr_type_i(csr_type_i), .csr_addr_i(csr_addr_i),
        .csr_wdata_i(csr_wdata_i), .pc_i(pc_i), .wb_ready_o(wb_ready_o), .reg_wen_o(reg_wen_o),
        .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o), .csr_raddr_i(csr_raddr_i),
        .csr_rdata_o(csr_rdata_o), .wb_valid_o(wb_valid_o), .redirect_o(redirect_o),
        .redirect_pc_o(redirect_pc_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_read(input logic [11:0] a);
        case (a)
            12'h300: return m_mstatus;
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
`ifdef YSYX_22041211_WBU_INSTRET_EN
            12'hB02: return m_instret[31:0];
            12'hB82: return m_instret[63:32];
`endif
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_mstatus = 32'h1800; m_mtvec = 0; m_mepc = 0; m_mcause = 0; m_instret = 0;
        sb.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        lsu_valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!wb_ready_o && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (!wb_ready_o) begin
            tests_run++; fails++;
            $display("FAIL ready_timeout: wb_ready_o=%b required 1", wb_ready_o);
        end
    endtask

    // Drive one instruction, predict its outcome, then follow it through COMMIT and DONE.
    task automatic txn(input logic wd, input logic [4:0] wreg, input logic [31:0] wdata,
                       input logic [2:0] ctype, input logic [11:0] caddr,
                       input logic [31:0] cwdata, input logic [31:0] pc);
        exp_t e;
        wait_ready();
        wd_i = wd; wreg_i = wreg; wdata_i = wdata; csr_type_i = ctype;
        csr_addr_i = caddr; csr_wdata_i = cwdata; pc_i = pc; lsu_valid_i = 1'b1;
        e.wen = wd && (wreg != 5'd0);
        e.waddr = wreg;
        e.wdata = wdata;
        e.rd_commit = model_read(csr_raddr_i);
        if (ctype == 3'b001) begin
            case (caddr)
                12'h300: m_mstatus = cwdata;
                12'h305: m_mtvec = cwdata;
                12'h341: m_mepc = cwdata;
                12'h342: m_mcause = cwdata;
`ifdef YSYX_22041211_WBU_INSTRET_EN
                12'hB02: m_instret[31:0] = cwdata;
                12'hB82: m_instret[63:32] = cwdata;
`endif
                default: ;
            endcase
        end else if (ctype == 3'b010) begin
            m_mepc = pc; m_mcause = 32'd11;
        end
        e.redir = (ctype == 3'b010) || (ctype == 3'b011);
        e.rpc = (ctype == 3'b010) ? m_mtvec : (ctype == 3'b011) ? m_mepc : 32'h0;
        e.rd_done = model_read(csr_raddr_i);
        sb.push_back(e);
        m_instret = m_instret + 64'd1;

        @(posedge clk); #1;
        lsu_valid_i = 1'b0;
        tests_run++;
        if (sb.size() == 0) begin
            fails++; $display("FAIL sb_empty: no expected entry queued");
            return;
        end
        e = sb.pop_front();
        tests_run++;
        if (reg_wen_o !== e.wen) begin
            fails++; $display("FAIL commit_wen: got %b exp %b", reg_wen_o, e.wen);
        end
        if (e.wen) begin
            tests_run++;
            if (reg_waddr_o !== e.waddr || reg_wdata_o !== e.wdata) begin
                fails++;
                $display("FAIL commit_wdata: got x%0d=%h exp x%0d=%h",
                         reg_waddr_o, reg_wdata_o, e.waddr, e.wdata);
            end
        end
        tests_run++;
        if (wb_ready_o !== 1'b0 || wb_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL commit_busy: ready=%b valid=%b exp 0 0", wb_ready_o, wb_valid_o);
        end
        tests_run++;
        if (csr_rdata_o !== e.rd_commit) begin
            fails++; $display("FAIL commit_csr_read: got %h exp %h", csr_rdata_o, e.rd_commit);
        end

        @(posedge clk); #1;
        tests_run++;
        if (wb_valid_o !== 1'b1 || reg_wen_o !== 1'b0) begin
            fails++; $display("FAIL done_valid: valid=%b wen=%b exp 1 0", wb_valid_o, reg_wen_o);
        end
        tests_run++;
        if (redirect_o !== e.redir || redirect_pc_o !== e.rpc) begin
            fails++;
            $display("FAIL done_redirect: got %b/%h exp %b/%h",
                     redirect_o, redirect_pc_o, e.redir, e.rpc);
        end
        tests_run++;
        if (csr_rdata_o !== e.rd_done) begin
            fails++; $display("FAIL done_csr_read: got %h exp %h", csr_rdata_o, e.rd_done);
        end

        @(posedge clk); #1;
        tests_run++;
        if (wb_ready_o !== 1'b1 || wb_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL idle_ready: ready=%b valid=%b exp 1 0", wb_ready_o, wb_valid_o);
        end
    endtask

    task automatic check_csr(input logic [11:0] a, input string name);
        csr_raddr_i = a; #1;
        tests_run++;
        if (csr_rdata_o !== model_read(a)) begin
            fails++; $display("FAIL %s: got %h exp %h", name, csr_rdata_o, model_read(a));
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (wb_ready_o !== 1'b1 || reg_wen_o !== 1'b0 || wb_valid_o !== 1'b0 ||
            redirect_o !== 1'b0 || redirect_pc_o !== 32'h0) begin
            fails++;
            $display("FAIL reset_outputs: ready=%b wen=%b valid=%b redir=%b pc=%h",
                     wb_ready_o, reg_wen_o, wb_valid_o, redirect_o, redirect_pc_o);
        end
        csr_raddr_i = 12'h300; #1;
        tests_run++;
        if (csr_rdata_o !== 32'h1800) begin
            fails++; $display("FAIL reset_mstatus: got %h exp 00001800", csr_rdata_o);
        end
        check_csr(12'h305, "reset_mtvec");
        check_csr(12'h342, "reset_mcause");
    endtask

    task automatic test_gpr_write();
        txn(1'b1, 5'd5, 32'hDEADBEEF, 3'b000, 12'h0, 32'h0, 32'h8000_0000);
    endtask

    task automatic test_x0();
        txn(1'b1, 5'd0, 32'h0000_1234, 3'b000, 12'h0, 32'h0, 32'h8000_0004);
        txn(1'b0, 5'd9, 32'h0000_5678, 3'b000, 12'h0, 32'h0, 32'h8000_0008);
    endtask

    task automatic test_csr_ecall();
        csr_raddr_i = 12'h305;
        txn(1'b0, 5'd0, 32'h0, 3'b001, 12'h305, 32'h8000_0100, 32'h8000_0010);
        check_csr(12'h305, "csrw_mtvec");
        csr_raddr_i = 12'h341;
        txn(1'b0, 5'd0, 32'h0, 3'b010, 12'h0, 32'h0, 32'h8000_0040);
        check_csr(12'h341, "ecall_mepc");
        check_csr(12'h342, "ecall_mcause");
    endtask

    task automatic test_mret();
        csr_raddr_i = 12'h341;
        txn(1'b0, 5'd0, 32'h0, 3'b011, 12'h0, 32'h0, 32'h8000_0100);
        csr_raddr_i = 12'h7C0;
        txn(1'b1, 5'd1, 32'h1, 3'b001, 12'h7C0, 32'hFFFF_FFFF, 32'h8000_0044);
        // Reserved code 100 with a CSRW-like payload must have no CSR effect.
        csr_raddr_i = 12'h305;
        txn(1'b0, 5'd0, 32'h0, 3'b100, 12'h305, 32'h0, 32'h8000_0048);
        check_csr(12'h7C0, "unknown_csr_read");
        check_csr(12'h300, "mret_mstatus");
        check_csr(12'h305, "mret_mtvec");
        check_csr(12'h341, "mret_mepc");
        check_csr(12'h342, "mret_mcause");
    endtask

    task automatic test_back_to_back();
        wait_ready();
        wd_i = 1'b1; wreg_i = 5'd7; wdata_i = 32'h55; csr_type_i = 3'b000; lsu_valid_i = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            tests_run++;
            if (reg_wen_o !== (i % 3 == 0) || wb_valid_o !== (i % 3 == 1) ||
                wb_ready_o !== (i % 3 == 2)) begin
                fails++;
                $display("FAIL b2b_cycle%0d: wen=%b valid=%b ready=%b exp %b %b %b", i,
                         reg_wen_o, wb_valid_o, wb_ready_o, i % 3 == 0, i % 3 == 1, i % 3 == 2);
            end
            if (i == 8) lsu_valid_i = 1'b0;
        end
        m_instret = m_instret + 64'd3;
    endtask

    task automatic test_reset_mid();
        wait_ready();
        wd_i = 1'b1; wreg_i = 5'd3; wdata_i = 32'hABCD; csr_type_i = 3'b001;
        csr_addr_i = 12'h300; csr_wdata_i = 32'h0; lsu_valid_i = 1'b1;
        @(posedge clk); #1;
        lsu_valid_i = 1'b0;
        rst = 1'b1; #1;
        tests_run++;
        if (reg_wen_o !== 1'b0 || wb_ready_o !== 1'b0) begin
            fails++;
            $display("FAIL rst_commit_wen: wen=%b ready=%b exp 0 0", reg_wen_o, wb_ready_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        tests_run++;
        if (wb_valid_o !== 1'b0 || wb_ready_o !== 1'b1) begin
            fails++;
            $display("FAIL rst_no_valid: valid=%b ready=%b exp 0 1", wb_valid_o, wb_ready_o);
        end
        csr_raddr_i = 12'h300; #1;
        tests_run++;
        if (csr_rdata_o !== 32'h1800) begin
            fails++; $display("FAIL rst_mstatus: got %h exp 00001800", csr_rdata_o);
        end
        check_csr(12'h305, "rst_mtvec");
        @(posedge clk); #1;
        tests_run++;
        if (wb_valid_o !== 1'b0 || reg_wen_o !== 1'b0) begin
            fails++; $display("FAIL rst_quiet: valid=%b wen=%b exp 0 0", wb_valid_o, reg_wen_o);
        end
    endtask

    task automatic test_instret();
        do_reset();
        for (int i = 0; i < 4; i++)
            txn(1'b1, 5'(i + 1), 32'(i), 3'b000, 12'h0, 32'h0, 32'h8000_0000 + 32'(4 * i));
        csr_raddr_i = 12'hB02; #1;
        tests_run++;
`ifdef YSYX_22041211_WBU_INSTRET_EN
        if (csr_rdata_o !== 32'd4) begin
            fails++; $display("FAIL instret_lo: got %h exp 00000004", csr_rdata_o);
        end
`else
        if (csr_rdata_o !== 32'd0) begin
            fails++; $display("FAIL instret_lo_absent: got %h exp 00000000", csr_rdata_o);
        end
`endif
        csr_raddr_i = 12'hB82; #1;
        tests_run++;
        if (csr_rdata_o !== 32'd0) begin
            fails++; $display("FAIL instret_hi: got %h exp 00000000", csr_rdata_o);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_gpr_write();
        test_x0();
        test_csr_ecall();
        test_mret();
        test_back_to_back();
        test_reset_mid();
        test_instret();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
